// File: rtl/la_sample_conditioner.sv
// Probe front-end for the capture core: synchronize, glitch-filter and decimate
// raw probe inputs, and align the asynchronous external trigger to a sample strobe.
module la_sample_conditioner #(
  parameter int unsigned CAPTURE_WIDTH = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_BITS   = 4
) (
  input  logic                     cap_clk,
  input  logic                     rst,
  input  logic [CAPTURE_WIDTH-1:0] raw_data,
  input  logic                     raw_ext_trigger,
  input  logic [31:0]              clk_div,
  input  logic [FILTER_BITS-1:0]   filter_len,
  input  logic                     ext_trig_polarity,
  input  logic                     set_strobe,
  input  logic                     enable,
  output logic [CAPTURE_WIDTH-1:0] sample_data,
  output logic                     sample_valid,
  output logic                     ext_trigger_pulse,
  output logic [31:0]              sample_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  localparam logic [1:0] ARM_LAST = 2'(SYNC_STAGES - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_tick;

  logic [CAPTURE_WIDTH-1:0] r_sync_data [SYNC_STAGES];
  logic [SYNC_STAGES-1:0]   r_sync_trig;
  logic [CAPTURE_WIDTH-1:0] w_sync;
  logic                     w_trig;

  logic [31:0]              r_div_sh;
  logic [FILTER_BITS-1:0]   r_flen_sh;
  logic                     r_pol_sh;

  logic [1:0]               r_arm_cnt;
  logic [31:0]              r_div_cnt;
  logic [FILTER_BITS-1:0]   r_stab;
  logic [FILTER_BITS-1:0]   w_stab;
  logic [CAPTURE_WIDTH-1:0] r_sync_prev;
  logic [CAPTURE_WIDTH-1:0] r_filt;
  logic [CAPTURE_WIDTH-1:0] w_filt;
  logic                     w_changed;

  logic                     r_trig_prev;
  logic                     w_edge;
  logic                     r_pending;

  logic [CAPTURE_WIDTH-1:0] r_sample_data;
  logic                     r_valid;
  logic                     r_pulse;
  logic [31:0]              r_sample_count;

  // Synchronizer chains run in every non-reset cycle, including set_strobe cycles.
  always_ff @(posedge cap_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync_data[i] <= '0;
      r_sync_trig <= '0;
    end else begin
      r_sync_data[0] <= raw_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync_data[i] <= r_sync_data[i-1];
      r_sync_trig <= {r_sync_trig[SYNC_STAGES-2:0], raw_ext_trigger};
    end
  end

  assign w_sync = r_sync_data[SYNC_STAGES-1];
  assign w_trig = r_sync_trig[SYNC_STAGES-1];

  always_ff @(posedge cap_clk) begin
    if (rst) begin
      r_div_sh  <= '0;
      r_flen_sh <= '0;
      r_pol_sh  <= 1'b0;
    end else if (set_strobe) begin
      r_div_sh  <= clk_div;
      r_flen_sh <= filter_len;
      r_pol_sh  <= ext_trig_polarity;
    end
  end

  always_ff @(posedge cap_clk) begin
    if (rst || set_strobe) r_state <= S_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    case (r_state)
      S_IDLE: if (enable) w_state_nxt = S_ARM;
      S_ARM: begin
        if (!enable)                    w_state_nxt = S_IDLE;
        else if (r_arm_cnt == ARM_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_tick = (r_div_cnt == r_div_sh);
        if (!enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The stability count is evaluated combinationally so a word stable for
  // filter_len cycles is usable in the very cycle it qualifies.
  assign w_changed = (w_sync != r_sync_prev);

  always_comb begin
    w_stab = r_stab;
    if (w_changed)          w_stab = '0;
    else if (r_stab != '1)  w_stab = r_stab + 1'b1;
    w_filt = r_filt;
    if (r_flen_sh == '0 || w_stab == r_flen_sh - 1'b1) w_filt = w_sync;
  end

  assign w_edge = (w_trig ^ r_pol_sh) & ~(r_trig_prev ^ r_pol_sh);

  always_ff @(posedge cap_clk) begin
    if (rst || set_strobe) begin
      r_arm_cnt      <= '0;
      r_div_cnt      <= '0;
      r_stab         <= '0;
      r_pending      <= 1'b0;
      r_valid        <= 1'b0;
      r_pulse        <= 1'b0;
      r_sample_count <= '0;
    end else begin
      r_arm_cnt <= (r_state == S_ARM) ? r_arm_cnt + 2'd1 : '0;
      r_div_cnt <= (r_state != S_RUN || w_tick) ? '0 : r_div_cnt + 32'd1;
      r_stab    <= w_stab;
      r_valid   <= w_tick;
      r_pulse   <= w_tick & (r_pending | w_edge);
      if (r_state != S_RUN || w_tick) r_pending <= 1'b0;
      else if (w_edge)                r_pending <= 1'b1;
      if (w_tick && r_sample_count != '1) r_sample_count <= r_sample_count + 32'd1;
    end
  end

  always_ff @(posedge cap_clk) begin
    if (rst) begin
      r_sync_prev   <= '0;
      r_trig_prev   <= 1'b0;
      r_filt        <= '0;
      r_sample_data <= '0;
    end else begin
      r_sync_prev <= w_sync;
      r_trig_prev <= w_trig;
      if (!set_strobe) begin
        r_filt <= (r_state == S_ARM) ? w_sync : w_filt;
        if (w_tick) r_sample_data <= w_filt;
      end
    end
  end

  // Strobes drop in the same cycle reset is raised, not one edge later.
  assign sample_data       = r_sample_data;
  assign sample_valid      = r_valid & ~rst;
  assign ext_trigger_pulse = r_pulse & ~rst;
  assign sample_count      = r_sample_count;

endmodule

// File: tb/tb_la_sample_conditioner.sv
// Directed + randomized bench for la_sample_conditioner against a behavioural model
// built from delay lines, stability age, modulo decimation and saturating counts.
module tb_la_sample_conditioner;

  localparam int SS = 2;
  localparam int CW = 32;
  localparam int FB = 4;

  logic          cap_clk;
  logic          rst;
  logic [CW-1:0] raw_data;
  logic          raw_ext_trigger;
  logic [31:0]   clk_div;
  logic [FB-1:0] filter_len;
  logic          ext_trig_polarity;
  logic          set_strobe;
  logic          enable;
  logic [CW-1:0] sample_data;
  logic          sample_valid;
  logic          ext_trigger_pulse;
  logic [31:0]   sample_count;

  int n_checks = 0;
  int n_errors = 0;

  la_sample_conditioner #(
    .CAPTURE_WIDTH(CW),
    .SYNC_STAGES(SS),
    .FILTER_BITS(FB)
  ) dut (
    .cap_clk(cap_clk),
    .rst(rst),
    .raw_data(raw_data),
    .raw_ext_trigger(raw_ext_trigger),
    .clk_div(clk_div),
    .filter_len(filter_len),
    .ext_trig_polarity(ext_trig_polarity),
    .set_strobe(set_strobe),
    .enable(enable),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .ext_trigger_pulse(ext_trigger_pulse),
    .sample_count(sample_count)
  );

  initial cap_clk = 1'b0;
  always #5 cap_clk = ~cap_clk;

  // Behavioural model state
  logic [CW-1:0] m_dl [SS];
  logic          m_tl [SS];
  logic [CW-1:0] m_psy;
  logic          m_pty;
  longint        m_cyc = 0;
  longint        m_anchor = 0;
  longint        m_div = 0;
  int            m_flen = 0;
  logic          m_pol = 1'b0;
  int            m_mode = 0;   // 0 idle, 1 arm, 2 run
  int            m_arm_n = 0;
  longint        m_run_n = 0;
  logic [CW-1:0] m_filt, m_data;
  logic          m_valid, m_pulse, m_pend;
  longint        m_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [CW-1:0] sy, fw;
    logic          ty, chg, tick, edg;
    longint        age;
    sy   = m_dl[SS-1];
    ty   = m_tl[SS-1];
    chg  = (sy != m_psy);
    age  = chg ? 0 : (((m_cyc - m_anchor) > 15) ? 15 : (m_cyc - m_anchor));
    fw   = (m_flen == 0 || age == longint'(m_flen - 1)) ? sy : m_filt;
    tick = (m_mode == 2) && ((m_run_n % (m_div + 1)) == m_div);
    edg  = ((ty ^ m_pol) == 1'b1) && ((m_pty ^ m_pol) == 1'b0);
    if (rst) begin
      for (int i = 0; i < SS; i++) begin m_dl[i] = '0; m_tl[i] = 1'b0; end
      m_psy = '0; m_pty = 1'b0; m_anchor = m_cyc;
      m_div = 0; m_flen = 0; m_pol = 1'b0; m_mode = 0;
      m_filt = '0; m_data = '0; m_valid = 1'b0; m_pulse = 1'b0; m_pend = 1'b0; m_count = 0;
    end else begin
      for (int i = SS-1; i > 0; i--) begin m_dl[i] = m_dl[i-1]; m_tl[i] = m_tl[i-1]; end
      m_dl[0] = raw_data;
      m_tl[0] = raw_ext_trigger;
      m_psy = sy;
      m_pty = ty;
      if (set_strobe) begin
        m_div = longint'({32'h0, clk_div});
        m_flen = int'(filter_len);
        m_pol = ext_trig_polarity;
        m_mode = 0; m_anchor = m_cyc;
        m_pend = 1'b0; m_count = 0; m_valid = 1'b0; m_pulse = 1'b0;
      end else begin
        if (chg) m_anchor = m_cyc;
        m_filt = (m_mode == 1) ? sy : fw;
        m_valid = tick;
        m_pulse = tick && (m_pend || edg);
        if (tick) begin
          m_data = fw;
          if (m_count < 64'hFFFF_FFFF) m_count++;
        end
        if (m_mode != 2 || tick) m_pend = 1'b0;
        else if (edg)            m_pend = 1'b1;
        case (m_mode)
          0: if (enable) begin m_mode = 1; m_arm_n = 0; end
          1: begin
            if (!enable) m_mode = 0;
            else begin
              m_arm_n++;
              if (m_arm_n == SS) begin m_mode = 2; m_run_n = 0; end
            end
          end
          default: begin
            m_run_n++;
            if (!enable) m_mode = 0;
          end
        endcase
      end
    end
    m_cyc++;
  endtask

  task automatic compare();
    chk("sample_data", 64'(sample_data), 64'(m_data));
    chk("sample_valid", 64'(sample_valid), 64'(m_valid & ~rst));
    chk("ext_trigger_pulse", 64'(ext_trigger_pulse), 64'(m_pulse & ~rst));
    chk("sample_count", 64'(sample_count), 64'(m_count[31:0]));
    chk("pulse_without_valid", 64'(ext_trigger_pulse & ~sample_valid), 64'd0);
  endtask

  task automatic step();
    @(posedge cap_clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic strobe_cfg(input logic [31:0] div, input logic [FB-1:0] flen, input logic pol);
    clk_div = div; filter_len = flen; ext_trig_polarity = pol;
    set_strobe = 1'b1;
    step();
    set_strobe = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (m_mode != 2 && n < 32) begin step(); n++; end
    if (m_mode != 2) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    step();
    while (!m_valid && n < 64) begin step(); n++; end
    if (!m_valid) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic wait_phase(input int ph, input int modulus);
    int n = 0;
    while (((m_run_n + SS) % modulus) != ph && n < 64) begin step(); n++; end
    if (((m_run_n + SS) % modulus) != ph) chk("phase_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [CW-1:0] x, y;
    int vcnt;
    bit glitch_seen;
    rst = 1'b1; set_strobe = 1'b0; enable = 1'b0;
    raw_data = '0; raw_ext_trigger = 1'b0;
    clk_div = '0; filter_len = '0; ext_trig_polarity = 1'b0;
    for (int i = 0; i < SS; i++) begin m_dl[i] = '0; m_tl[i] = 1'b0; end
    m_psy = '0; m_pty = 1'b0;
    m_filt = '0; m_data = '0; m_valid = 1'b0; m_pulse = 1'b0; m_pend = 1'b0;
    repeat (3) step();
    chk("reset_data", 64'(sample_data), 64'd0);
    chk("reset_valid", 64'(sample_valid), 64'd0);
    chk("reset_count", 64'(sample_count), 64'd0);
    rst = 1'b0;
    repeat (2) step();

    // Bypass filter, no decimation: 3-cycle latency, valid every cycle
    strobe_cfg(32'd0, 4'd0, 1'b0);
    enable = 1'b1;
    wait_run("t1_run");
    repeat (4) step();
    raw_data = 32'hA5A5_A5A5;
    repeat (2) step();
    chk("t1_early", 64'(sample_data == 32'hA5A5_A5A5), 64'd0);
    step();
    chk("t1_latency", 64'(sample_data), 64'hA5A5_A5A5);
    for (int i = 0; i < 12; i++) begin
      raw_data = $urandom;
      step();
      chk("t1_valid_each", 64'(sample_valid), 64'd1);
    end

    // Decimate by 4, count samples, clear by set_strobe
    strobe_cfg(32'd3, 4'd0, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 100 && vcnt < 10; i++) begin
      raw_data = $urandom;
      step();
      if (m_valid) vcnt++;
    end
    chk("t2_count10", 64'(sample_count), 64'd10);
    strobe_cfg(32'd3, 4'd0, 1'b0);
    chk("t2_count_clear", 64'(sample_count), 64'd0);

    // Glitch filter
    x = $urandom;
    raw_data = x;
    strobe_cfg(32'd0, 4'd4, 1'b0);
    wait_run("t3_run");
    repeat (8) step();
    raw_data = x ^ 32'd1;
    repeat (2) step();
    raw_data = x;
    glitch_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sample_data === (x ^ 32'd1)) glitch_seen = 1'b1;
    end
    chk("t3_glitch_rejected", 64'(glitch_seen), 64'd0);
    y = x ^ 32'h0F0F_0003;
    raw_data = y;
    repeat (5) step();
    chk("t3_not_yet", 64'(sample_data == y), 64'd0);
    step();
    chk("t3_accepted", 64'(sample_data), 64'(y));

    // External trigger with div=7
    raw_ext_trigger = 1'b0;
    strobe_cfg(32'd7, 4'd0, 1'b0);
    wait_run("t4_run");
    repeat (16) step();
    wait_phase(3, 8);
    raw_ext_trigger = 1'b1;
    wait_valid("t4_valid1");
    chk("t4_single_pulse", 64'(ext_trigger_pulse), 64'd1);
    wait_valid("t4_valid2");
    chk("t4_no_repeat", 64'(ext_trigger_pulse), 64'd0);
    raw_ext_trigger = 1'b0;
    repeat (10) step();
    wait_phase(0, 8);
    raw_ext_trigger = 1'b1; step();
    raw_ext_trigger = 1'b0; step();
    raw_ext_trigger = 1'b1; step();
    wait_valid("t4_valid3");
    chk("t4_two_edges_one_pulse", 64'(ext_trigger_pulse), 64'd1);
    wait_valid("t4_valid4");
    chk("t4_two_edges_no_second", 64'(ext_trigger_pulse), 64'd0);
    strobe_cfg(32'd7, 4'd0, 1'b1);
    wait_run("t4_run_pol");
    repeat (16) step();
    wait_phase(2, 8);
    raw_ext_trigger = 1'b0;
    wait_valid("t4_valid5");
    chk("t4_falling_pulse", 64'(ext_trigger_pulse), 64'd1);

    // Edge coincident with a tick
    strobe_cfg(32'd7, 4'd0, 1'b0);
    wait_run("t5_run");
    repeat (16) step();
    wait_phase(7, 8);
    raw_ext_trigger = 1'b1;
    repeat (SS + 1) step();
    chk("t5_coincident_valid", 64'(sample_valid), 64'd1);
    chk("t5_coincident_pulse", 64'(ext_trigger_pulse), 64'd1);

    // Count saturation
    strobe_cfg(32'd0, 4'd0, 1'b0);
    wait_run("t5_run2");
    force dut.r_sample_count = 32'hFFFF_FFFE;
    m_count = 64'hFFFF_FFFE;
    #1;
    release dut.r_sample_count;
    repeat (3) step();
    chk("t5_saturate", 64'(sample_count), 64'hFFFF_FFFF);

    // Reset and set_strobe mid-run
    chk("t6_pre_valid", 64'(sample_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_valid_immediate", 64'(sample_valid), 64'd0);
    chk("t6_pulse_immediate", 64'(ext_trigger_pulse), 64'd0);
    step();
    chk("t6_rst_data", 64'(sample_data), 64'd0);
    chk("t6_rst_count", 64'(sample_count), 64'd0);
    step();
    rst = 1'b0;
    repeat (SS + 1) step();
    chk("t6_arm_no_valid", 64'(sample_valid), 64'd0);
    step();
    chk("t6_first_valid", 64'(sample_valid), 64'd1);
    repeat (3) step();
    strobe_cfg(32'd0, 4'd0, 1'b0);
    chk("t6_strobe_valid", 64'(sample_valid), 64'd0);
    chk("t6_strobe_count", 64'(sample_count), 64'd0);

    // Randomized soak
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        clk_div = 32'($urandom_range(0, 4));
        filter_len = 4'($urandom_range(0, 5));
        ext_trig_polarity = 1'($urandom_range(0, 1));
      end
      set_strobe = (r < 3);
      rst = (r == 99);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) raw_data = ($urandom_range(0, 1) == 0) ? $urandom : (raw_data ^ 32'd1);
      if ($urandom_range(0, 5) == 0) raw_ext_trigger = ~raw_ext_trigger;
      step();
    end
    set_strobe = 1'b0;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
